// File: rtl/register_alias_table_pkg.sv
// Shared rename constants for the register alias table, ROB and issuer.
// ROB_ENTRY/ARCH_ENTRY set the default alias and architectural register
// spaces; ARCH_ZERO_ID is the hard-wired zero register that is never renamed.
package register_alias_table_pkg;

    localparam int ROB_ENTRY       = 4;
    localparam int ARCH_ENTRY      = 32;
    localparam int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY);
    localparam int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY);
    localparam int ARCH_ZERO_ID    = 0;

endpackage

// File: rtl/register_alias_table_if.sv
// Rename bus between the pipeline (master) and the alias table (slave).
// master drives allocate/commit/flush requests and the two source lookup ids;
// slave returns per-source valid/alias and the current mapping count.
interface register_alias_table_if
    import register_alias_table_pkg::*;
#(
    parameter int ROB_W  = ROB_ENTRY_LOG2,
    parameter int ARCH_W = ARCH_ENTRY_LOG2
);
    logic              rat_register_request;
    logic [ARCH_W-1:0] rat_register_arch_id;
    logic [ROB_W-1:0]  rat_register_alias;
    logic              rat_register_remove;
    logic [ARCH_W-1:0] rat_remove_arch_id;
    logic [ROB_W-1:0]  rat_remove_alias;
    logic              rat_flush;
    logic [ARCH_W-1:0] rat_rs1_arch_id;
    logic [ARCH_W-1:0] rat_rs2_arch_id;
    logic              rat_rs1_valid;
    logic              rat_rs2_valid;
    logic [ROB_W-1:0]  rat_rs1_alias;
    logic [ROB_W-1:0]  rat_rs2_alias;
    logic [ARCH_W:0]   rat_mapped_count;

    modport master (
        output rat_register_request, rat_register_arch_id, rat_register_alias,
        output rat_register_remove, rat_remove_arch_id, rat_remove_alias,
        output rat_flush, rat_rs1_arch_id, rat_rs2_arch_id,
        input  rat_rs1_valid, rat_rs2_valid, rat_rs1_alias, rat_rs2_alias,
        input  rat_mapped_count
    );

    modport slave (
        input  rat_register_request, rat_register_arch_id, rat_register_alias,
        input  rat_register_remove, rat_remove_arch_id, rat_remove_alias,
        input  rat_flush, rat_rs1_arch_id, rat_rs2_arch_id,
        output rat_rs1_valid, rat_rs2_valid, rat_rs1_alias, rat_rs2_alias,
        output rat_mapped_count
    );

endinterface

// File: rtl/rat_read_port.sv
// Combinational source lookup into the alias table.
// Ports: arch_id (lookup index), valid_tbl/alias_tbl (registered table),
// valid (source renamed), rob_alias (ROB entry, forced 0 when not valid).
module rat_read_port
    import register_alias_table_pkg::*;
#(
    parameter int ROB_W  = 2,
    parameter int N_ARCH = 32,
    parameter int ARCH_W = 5
) (
    input  logic [ARCH_W-1:0]             arch_id,
    input  logic [N_ARCH-1:0]             valid_tbl,
    input  logic [N_ARCH-1:0][ROB_W-1:0]  alias_tbl,
    output logic                          valid,
    output logic [ROB_W-1:0]              rob_alias
);

    localparam logic [ARCH_W-1:0] ZERO_ID = ARCH_W'(ARCH_ZERO_ID);

    // Entry 0 is masked here as well so a lookup of the zero register can
    // never report a mapping, whatever the table holds.
    always_comb begin
        valid     = (arch_id != ZERO_ID) && valid_tbl[arch_id];
        rob_alias = valid ? alias_tbl[arch_id] : '0;
    end

endmodule

// File: rtl/register_alias_table.sv
// Register alias table: maps architectural registers to in-flight ROB entries.
// Ports: CLK, RST (sync, active-high), rat_bus (slave side of the rename bus:
// allocate, commit-remove, flush, two source lookups, mapping count).
// Updates are registered; lookups see the table as of the last edge.
module register_alias_table #(
    parameter int ROB_ENTRY  = register_alias_table_pkg::ROB_ENTRY,
    parameter int ARCH_ENTRY = register_alias_table_pkg::ARCH_ENTRY
) (
    input  logic                  CLK,
    input  logic                  RST,
    register_alias_table_if.slave rat_bus
);

    localparam int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY);
    localparam int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY);
    localparam int CNT_W           = ARCH_ENTRY_LOG2 + 1;
    localparam logic [ARCH_ENTRY_LOG2-1:0] ZERO_ID =
        ARCH_ENTRY_LOG2'(register_alias_table_pkg::ARCH_ZERO_ID);

    logic [ARCH_ENTRY-1:0]                     valid_q;
    logic [ARCH_ENTRY-1:0][ROB_ENTRY_LOG2-1:0] alias_q;
    logic [CNT_W-1:0]                          count_q;

    logic req_ok;
    logic rem_ok;
    logic inc;

    always_comb begin
        req_ok = rat_bus.rat_register_request
                 && (rat_bus.rat_register_arch_id != ZERO_ID);
        // A commit only retires the mapping it created; if a younger
        // instruction has since renamed the register the alias differs and
        // the entry is left alone. A same-cycle request to that register wins.
        rem_ok = rat_bus.rat_register_remove
                 && valid_q[rat_bus.rat_remove_arch_id]
                 && (alias_q[rat_bus.rat_remove_arch_id] == rat_bus.rat_remove_alias)
                 && !(req_ok && (rat_bus.rat_register_arch_id == rat_bus.rat_remove_arch_id));
        inc    = req_ok && !valid_q[rat_bus.rat_register_arch_id];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            alias_q <= '0;
            count_q <= '0;
        end else if (rat_bus.rat_flush) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (rem_ok) begin
                valid_q[rat_bus.rat_remove_arch_id] <= 1'b0;
            end
            if (req_ok) begin
                valid_q[rat_bus.rat_register_arch_id] <= 1'b1;
                alias_q[rat_bus.rat_register_arch_id] <= rat_bus.rat_register_alias;
            end
            count_q <= count_q + CNT_W'(inc) - CNT_W'(rem_ok);
        end
    end

    assign rat_bus.rat_mapped_count = count_q;

    rat_read_port #(
        .ROB_W  (ROB_ENTRY_LOG2),
        .N_ARCH (ARCH_ENTRY),
        .ARCH_W (ARCH_ENTRY_LOG2)
    ) u_rs1_port (
        .arch_id   (rat_bus.rat_rs1_arch_id),
        .valid_tbl (valid_q),
        .alias_tbl (alias_q),
        .valid     (rat_bus.rat_rs1_valid),
        .rob_alias (rat_bus.rat_rs1_alias)
    );

    rat_read_port #(
        .ROB_W  (ROB_ENTRY_LOG2),
        .N_ARCH (ARCH_ENTRY),
        .ARCH_W (ARCH_ENTRY_LOG2)
    ) u_rs2_port (
        .arch_id   (rat_bus.rat_rs2_arch_id),
        .valid_tbl (valid_q),
        .alias_tbl (alias_q),
        .valid     (rat_bus.rat_rs2_valid),
        .rob_alias (rat_bus.rat_rs2_alias)
    );

endmodule

// File: tb/tb_register_alias_table.sv
// Directed bench for register_alias_table with hand-computed expectations.
module tb_register_alias_table;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    register_alias_table_if #(.ROB_W(2), .ARCH_W(5)) bus ();

    register_alias_table #(.ROB_ENTRY(4), .ARCH_ENTRY(32)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .rat_bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.rat_register_request = 1'b0;
        bus.rat_register_remove  = 1'b0;
        bus.rat_flush            = 1'b0;
    endtask

    task automatic req(input int arch, input int al);
        bus.rat_register_request = 1'b1;
        bus.rat_register_arch_id = 5'(arch);
        bus.rat_register_alias   = 2'(al);
    endtask

    task automatic rem(input int arch, input int al);
        bus.rat_register_remove = 1'b1;
        bus.rat_remove_arch_id  = 5'(arch);
        bus.rat_remove_alias    = 2'(al);
    endtask

    task automatic map_one(input int arch, input int al);
        req(arch, al);
        tick();
        idle();
    endtask

    task automatic look(input int a1, input int a2);
        bus.rat_rs1_arch_id = 5'(a1);
        bus.rat_rs2_arch_id = 5'(a2);
        #1;
    endtask

    initial begin
        idle();
        bus.rat_register_arch_id = '0;
        bus.rat_register_alias   = '0;
        bus.rat_remove_arch_id   = '0;
        bus.rat_remove_alias     = '0;
        bus.rat_rs1_arch_id      = '0;
        bus.rat_rs2_arch_id      = '0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;

        // reset state
        look(5, 0);
        check_eq("rst_rs1_valid", int'(bus.rat_rs1_valid), 0);
        check_eq("rst_rs2_valid", int'(bus.rat_rs2_valid), 0);
        check_eq("rst_rs1_alias", int'(bus.rat_rs1_alias), 0);
        check_eq("rst_rs2_alias", int'(bus.rat_rs2_alias), 0);
        check_eq("rst_count", int'(bus.rat_mapped_count), 0);

        // allocate 5->2, no same-cycle bypass
        req(5, 2);
        #1;
        check_eq("same_cycle_valid", int'(bus.rat_rs1_valid), 0);
        tick();
        idle();
        look(5, 0);
        check_eq("a5_valid", int'(bus.rat_rs1_valid), 1);
        check_eq("a5_alias", int'(bus.rat_rs1_alias), 2);
        check_eq("a5_count", int'(bus.rat_mapped_count), 1);

        // 7->1, 7->3 (remap), stale remove 7/1, then real remove 7/3
        map_one(7, 1);
        map_one(7, 3);
        look(7, 5);
        check_eq("remap_count", int'(bus.rat_mapped_count), 2);
        rem(7, 1);
        tick();
        idle();
        look(7, 5);
        check_eq("stale_rm_valid", int'(bus.rat_rs1_valid), 1);
        check_eq("stale_rm_alias", int'(bus.rat_rs1_alias), 3);
        check_eq("stale_rm_count", int'(bus.rat_mapped_count), 2);
        rem(7, 3);
        tick();
        idle();
        look(7, 5);
        check_eq("rm7_valid", int'(bus.rat_rs1_valid), 0);
        check_eq("rm7_alias", int'(bus.rat_rs1_alias), 0);
        check_eq("rm7_count", int'(bus.rat_mapped_count), 1);
        check_eq("rm7_other_valid", int'(bus.rat_rs2_valid), 1);

        // 9->2, then request 9->0 and remove 9/2 in the same cycle
        map_one(9, 2);
        look(9, 5);
        check_eq("a9_count", int'(bus.rat_mapped_count), 2);
        req(9, 0);
        rem(9, 2);
        tick();
        idle();
        look(9, 5);
        check_eq("collide_valid", int'(bus.rat_rs1_valid), 1);
        check_eq("collide_alias", int'(bus.rat_rs1_alias), 0);
        check_eq("collide_count", int'(bus.rat_mapped_count), 2);

        // request to the zero register is ignored
        map_one(0, 1);
        look(0, 9);
        check_eq("zero_valid", int'(bus.rat_rs1_valid), 0);
        check_eq("zero_alias", int'(bus.rat_rs1_alias), 0);
        check_eq("zero_count", int'(bus.rat_mapped_count), 2);

        // request 11->1 and remove 5/2 in the same cycle: both apply
        req(11, 1);
        rem(5, 2);
        tick();
        idle();
        look(11, 5);
        check_eq("dual_req_valid", int'(bus.rat_rs1_valid), 1);
        check_eq("dual_req_alias", int'(bus.rat_rs1_alias), 1);
        check_eq("dual_rm_valid", int'(bus.rat_rs2_valid), 0);
        check_eq("dual_count", int'(bus.rat_mapped_count), 2);

        // map 1..4 (9 and 11 still mapped), then flush with a request to 6
        for (int i = 1; i <= 4; i++) map_one(i, i - 1);
        look(4, 1);
        check_eq("pre_flush_count", int'(bus.rat_mapped_count), 6);
        check_eq("pre_flush_alias4", int'(bus.rat_rs1_alias), 3);
        req(6, 1);
        bus.rat_flush = 1'b1;
        tick();
        idle();
        look(6, 1);
        check_eq("flush_count", int'(bus.rat_mapped_count), 0);
        for (int i = 0; i < 32; i++) begin
            look(i, 31 - i);
            check_eq($sformatf("flush_v1_%0d", i), int'(bus.rat_rs1_valid), 0);
            check_eq($sformatf("flush_v2_%0d", i), int'(bus.rat_rs2_valid), 0);
        end

        // map 1..3, then RST together with a request to 8
        for (int i = 1; i <= 3; i++) map_one(i, 3);
        look(3, 2);
        check_eq("pre_rst_count", int'(bus.rat_mapped_count), 3);
        check_eq("pre_rst_valid", int'(bus.rat_rs1_valid), 1);
        req(8, 2);
        RST = 1'b1;
        tick();
        idle();
        look(8, 1);
        check_eq("in_rst_v1", int'(bus.rat_rs1_valid), 0);
        check_eq("in_rst_v2", int'(bus.rat_rs2_valid), 0);
        check_eq("in_rst_count", int'(bus.rat_mapped_count), 0);
        RST = 1'b0;
        tick();
        look(8, 3);
        check_eq("post_rst_v1", int'(bus.rat_rs1_valid), 0);
        check_eq("post_rst_v2", int'(bus.rat_rs2_valid), 0);
        check_eq("post_rst_a2", int'(bus.rat_rs2_alias), 0);
        check_eq("post_rst_count", int'(bus.rat_mapped_count), 0);

        // table still works after reset
        map_one(8, 3);
        look(8, 0);
        check_eq("after_rst_valid", int'(bus.rat_rs1_valid), 1);
        check_eq("after_rst_alias", int'(bus.rat_rs1_alias), 3);
        check_eq("after_rst_count", int'(bus.rat_mapped_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
